// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU with valid/ready handshake, iterative MUL/DIV and registered flags
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 zero,
    output logic                 carry,
    output logic                 div_by_zero,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic mul_op, accept, fast, last, cy;
    logic [WIDTH-1:0] b_r, mp, q, rem, q_nxt, rem_nxt;
    logic [WIDTH:0] ea, eb, r_sh, diff;
    logic [2*WIDTH-1:0] mc, acc, acc_nxt, res, fin;
    assign accept = in_valid && in_ready;
    assign fast = !(opcode == 4'd4 || (opcode == 4'd5 && b != '0));
    assign last = cnt == CW'(WIDTH - 1);
    assign ea = {1'b0, a};
    assign eb = {1'b0, b};
    // single-cycle result straight from the live operands, registered on accept
    always_comb begin
        res = '0;
        case (opcode)
            4'd0:  res[WIDTH:0] = ea + eb;
            4'd1:  res[WIDTH:0] = ea + 1'b1;
            4'd2:  res[WIDTH:0] = ea - eb;
            4'd3:  res[WIDTH:0] = ea - 1'b1;
            4'd5:  res = b == '0 ? {a, {WIDTH{1'b1}}} : '0;
            4'd6:  res[WIDTH:0] = {a, 1'b0};
            4'd7:  res[WIDTH-1:0] = a >> 1;
            4'd8:  res[WIDTH-1:0] = a & b;
            4'd9:  res[WIDTH-1:0] = a | b;
            4'd10: res[WIDTH-1:0] = ~a;
            4'd11: res[WIDTH-1:0] = ~(a & b);
            4'd12: res[WIDTH-1:0] = ~(a | b);
            4'd13: res[WIDTH-1:0] = a ^ b;
            4'd14: res[WIDTH-1:0] = ~(a ^ b);
            4'd15: res[WIDTH-1:0] = a;
            default: res = '0;
        endcase
        cy = (opcode <= 4'd3 || opcode == 4'd6) && res[WIDTH];
    end
    // one shift-add step and one restoring-division step per BUSY cycle
    always_comb begin
        acc_nxt = acc + (mp[0] ? mc : '0);
        r_sh = {rem, q[WIDTH-1]};
        diff = r_sh - {1'b0, b_r};
        rem_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        q_nxt = {q[WIDTH-2:0], ~diff[WIDTH]};
        fin = mul_op ? acc_nxt : {rem_nxt, q_nxt};
    end
    // next state and handshake outputs decoded from the state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = accept ? (fast ? DONE : BUSY) : IDLE;
            BUSY: state_nxt = last ? DONE : BUSY;
            DONE: state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
        in_ready = state == IDLE;
        busy = state == BUSY;
        out_valid = state == DONE;
    end
    // state register and result/flag registers, written together on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out <= '0;
            zero <= 1'b0;
            carry <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && fast) begin
                out <= res;
                zero <= res == '0;
                carry <= cy;
                div_by_zero <= opcode == 4'd5;
            end else if (state == BUSY && last) begin
                out <= fin;
                zero <= fin == '0;
                carry <= 1'b0;
                div_by_zero <= 1'b0;
            end
        end
    end
    // iterative datapath: operands loaded on accept, stepped while BUSY
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_op <= opcode == 4'd4;
            b_r <= b;
            mc <= {{WIDTH{1'b0}}, a};
            mp <= b;
            acc <= '0;
            q <= a;
            rem <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CW'(1);
            mc <= mc << 1;
            mp <= mp >> 1;
            acc <= acc_nxt;
            q <= q_nxt;
            rem <= rem_nxt;
        end
    end
endmodule
